// File: rtl/result_matrix_serializer_if.sv
// Result element stream: one complex element of C per valid/ready transfer.
// The serializer drives the data side; the consumer drives OutReady.
interface result_matrix_serializer_if #(
  parameter int Width = 18
);
  logic                    OutValid;
  logic                    OutReady;
  logic signed [Width-1:0] OutReal;
  logic signed [Width-1:0] OutImag;
  logic [1:0]              OutRow;
  logic [1:0]              OutCol;
  logic                    OutLast;

  modport master (
    output OutValid,
    output OutReal,
    output OutImag,
    output OutRow,
    output OutCol,
    output OutLast,
    input  OutReady
  );

  modport slave (
    input  OutValid,
    input  OutReal,
    input  OutImag,
    input  OutRow,
    input  OutCol,
    input  OutLast,
    output OutReady
  );
endinterface

// File: rtl/result_matrix_serializer.sv
// Holds the 4x4 complex result matrix and streams it out row-major.
// Define RESULT_SERIALIZER_OVERRUN_EN to add the sticky Overrun flag.
module result_matrix_serializer #(
  parameter int Width = 18
) (
  input  logic                  CLK,
  input  logic                  reset,
  input  logic                  Load,
  input  logic [16*Width-1:0]   CRealFlat,
  input  logic [16*Width-1:0]   CImagFlat,
  output logic                  Busy,
  output logic                  Done,
`ifdef RESULT_SERIALIZER_OVERRUN_EN
  output logic                  Overrun,
`endif
  result_matrix_serializer_if.master out
);

  typedef enum logic [0:0] {
    IDLE,
    SEND
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [3:0] idx;
  logic [3:0] idx_nxt;

  logic signed [Width-1:0] re_q [16];
  logic signed [Width-1:0] im_q [16];

  logic send;
  logic last;
  logic xfer;
  logic capture;

  assign send = (state == SEND);
  assign last = (idx == 4'd15);

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    xfer      = 1'b0;
    capture   = 1'b0;
    unique case (1'b1)
      (state == IDLE): begin
        if (Load) begin
          capture   = 1'b1;
          idx_nxt   = 4'd0;
          state_nxt = SEND;
        end
      end
      (state == SEND): begin
        if (out.OutReady) begin
          xfer = 1'b1;
          if (last) begin
            idx_nxt = 4'd0;
            // A Load landing on the final transfer chains the next matrix.
            if (Load) begin
              capture = 1'b1;
            end else begin
              state_nxt = IDLE;
            end
          end else begin
            idx_nxt = idx + 4'd1;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_comb begin
    Busy         = send;
    out.OutValid = send;
    out.OutReal  = send ? re_q[idx] : '0;
    out.OutImag  = send ? im_q[idx] : '0;
    out.OutRow   = send ? idx[3:2] : 2'd0;
    out.OutCol   = send ? idx[1:0] : 2'd0;
    out.OutLast  = send && last;
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      state <= IDLE;
      idx   <= 4'd0;
      Done  <= 1'b0;
      for (int i = 0; i < 16; i++) begin
        re_q[i] <= '0;
        im_q[i] <= '0;
      end
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      Done  <= xfer && last;
      if (capture) begin
        for (int i = 0; i < 16; i++) begin
          re_q[i] <= CRealFlat[i*Width +: Width];
          im_q[i] <= CImagFlat[i*Width +: Width];
        end
      end
    end
  end

`ifdef RESULT_SERIALIZER_OVERRUN_EN
  always_ff @(posedge CLK) begin
    if (reset) begin
      Overrun <= 1'b0;
    end else if (Load && send && !capture) begin
      Overrun <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_result_matrix_serializer.sv
// Directed bench for result_matrix_serializer: stream order, stalls,
// ignored/chained loads, reset abort and width extremes.
module tb_result_matrix_serializer;

  localparam int W = 18;

  logic            CLK = 1'b0;
  logic            reset;
  logic            Load;
  logic [16*W-1:0] CRealFlat;
  logic [16*W-1:0] CImagFlat;
  logic            Busy;
  logic            Done;
`ifdef RESULT_SERIALIZER_OVERRUN_EN
  logic            Overrun;
`endif

  int n_cmp = 0;
  int n_err = 0;

  result_matrix_serializer_if #(.Width(W)) bus ();

  result_matrix_serializer #(.Width(W)) dut (
    .CLK       (CLK),
    .reset     (reset),
    .Load      (Load),
    .CRealFlat (CRealFlat),
    .CImagFlat (CImagFlat),
    .Busy      (Busy),
    .Done      (Done),
`ifdef RESULT_SERIALIZER_OVERRUN_EN
    .Overrun   (Overrun),
`endif
    .out       (bus)
  );

  always #5 CLK = ~CLK;

  // {valid, real, imag, row, col, last, busy}
  wire [42:0] obs = {bus.OutValid, bus.OutReal, bus.OutImag,
                     bus.OutRow, bus.OutCol, bus.OutLast, Busy};

  // kind 0: 16r+c / -(16r+c); 1: real 7; 2: real -1; 3: extremes at (1,2)
  function automatic logic signed [W-1:0] mre(int kind, int k);
    case (kind)
      0: return W'(16 * (k >> 2) + (k & 3));
      1: return W'(7);
      2: return W'(-1);
      default: return (k == 6) ? W'(-131072) : '0;
    endcase
  endfunction

  function automatic logic signed [W-1:0] mim(int kind, int k);
    case (kind)
      0: return W'(-(16 * (k >> 2) + (k & 3)));
      1, 2: return '0;
      default: return (k == 6) ? W'(131071) : '0;
    endcase
  endfunction

  function automatic logic [42:0] elem(int kind, int k);
    return {1'b1, mre(kind, k), mim(kind, k),
            2'(k >> 2), 2'(k & 3), (k == 15), 1'b1};
  endfunction

  task automatic drive_matrix(int kind);
    for (int k = 0; k < 16; k++) begin
      CRealFlat[k*W +: W] = mre(kind, k);
      CImagFlat[k*W +: W] = mim(kind, k);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    Load = 1'b0;
    bus.OutReady = 1'b0;
    drive_matrix(0);
    repeat (2) @(negedge CLK);
    n_cmp++;
    if ({obs, Done} !== 44'd0) begin
      n_err++;
      $display("FAIL reset_outputs got %h exp 0", {obs, Done});
    end
`ifdef RESULT_SERIALIZER_OVERRUN_EN
    n_cmp++;
    if (Overrun !== 1'b0) begin
      n_err++;
      $display("FAIL reset_overrun got %b exp 0", Overrun);
    end
`endif
    reset = 1'b0;
    bus.OutReady = 1'b1;
    repeat (2) @(negedge CLK);
    n_cmp++;
    if ({obs, Done} !== 44'd0) begin
      n_err++;
      $display("FAIL idle_ready_ignored got %h exp 0", {obs, Done});
    end
  endtask

  task automatic test_stream;
    drive_matrix(0);
    Load = 1'b1;
    bus.OutReady = 1'b1;
    @(negedge CLK);
    Load = 1'b0;
    for (int k = 0; k < 16; k++) begin
      n_cmp++;
      if (obs !== elem(0, k) || Done !== 1'b0) begin
        n_err++;
        $display("FAIL stream_elem k=%0d got %h/%b exp %h/0",
                 k, obs, Done, elem(0, k));
      end
      @(negedge CLK);
    end
    n_cmp++;
    if (obs !== 43'd0 || Done !== 1'b1) begin
      n_err++;
      $display("FAIL stream_done got %h/%b exp 0/1", obs, Done);
    end
    @(negedge CLK);
    n_cmp++;
    if (Done !== 1'b0) begin
      n_err++;
      $display("FAIL stream_done_pulse got %b exp 0", Done);
    end
  endtask

  task automatic test_stall;
    int k;
    int cyc;
    logic rdy;
    k = 0;
    cyc = 0;
    drive_matrix(0);
    Load = 1'b1;
    bus.OutReady = 1'b0;
    @(negedge CLK);
    Load = 1'b0;
    while (k < 16 && cyc < 100) begin
      n_cmp++;
      if (obs !== elem(0, k) || Done !== 1'b0) begin
        n_err++;
        $display("FAIL stall_elem k=%0d cyc=%0d got %h/%b exp %h/0",
                 k, cyc, obs, Done, elem(0, k));
      end
      rdy = (cyc % 4 == 0) || (cyc % 4 == 3);
      bus.OutReady = rdy;
      @(negedge CLK);
      if (rdy) k++;
      cyc++;
    end
    n_cmp++;
    if (k != 16) begin
      n_err++;
      $display("FAIL stall_timeout got k=%0d exp 16", k);
    end
    n_cmp++;
    if (obs !== 43'd0 || Done !== 1'b1) begin
      n_err++;
      $display("FAIL stall_done got %h/%b exp 0/1", obs, Done);
    end
    bus.OutReady = 1'b1;
    @(negedge CLK);
  endtask

  task automatic test_back_to_back;
    drive_matrix(0);
    Load = 1'b1;
    bus.OutReady = 1'b1;
    @(negedge CLK);
    Load = 1'b0;
    for (int k = 0; k < 16; k++) begin
      n_cmp++;
      if (obs !== elem(0, k)) begin
        n_err++;
        $display("FAIL b2b_first k=%0d got %h exp %h", k, obs, elem(0, k));
      end
      if (k == 15) begin
        drive_matrix(2);
        Load = 1'b1;
      end
      @(negedge CLK);
    end
    Load = 1'b0;
    n_cmp++;
    if (obs !== elem(2, 0) || Done !== 1'b1) begin
      n_err++;
      $display("FAIL b2b_chain got %h/%b exp %h/1", obs, Done, elem(2, 0));
    end
`ifdef RESULT_SERIALIZER_OVERRUN_EN
    n_cmp++;
    if (Overrun !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_overrun got %b exp 0", Overrun);
    end
`endif
    for (int k = 0; k < 16; k++) begin
      n_cmp++;
      if (obs !== elem(2, k)) begin
        n_err++;
        $display("FAIL b2b_second k=%0d got %h exp %h", k, obs, elem(2, k));
      end
      @(negedge CLK);
    end
    n_cmp++;
    if (obs !== 43'd0 || Done !== 1'b1) begin
      n_err++;
      $display("FAIL b2b_done got %h/%b exp 0/1", obs, Done);
    end
    @(negedge CLK);
  endtask

  task automatic test_overrun;
    drive_matrix(0);
    Load = 1'b1;
    bus.OutReady = 1'b1;
    @(negedge CLK);
    Load = 1'b0;
    for (int k = 0; k < 16; k++) begin
      n_cmp++;
      if (obs !== elem(0, k)) begin
        n_err++;
        $display("FAIL ovr_elem k=%0d got %h exp %h", k, obs, elem(0, k));
      end
`ifdef RESULT_SERIALIZER_OVERRUN_EN
      if (k == 6) begin
        n_cmp++;
        if (Overrun !== 1'b1) begin
          n_err++;
          $display("FAIL ovr_flag_set got %b exp 1", Overrun);
        end
      end
`endif
      if (k == 5) begin
        drive_matrix(1);
        Load = 1'b1;
      end else begin
        Load = 1'b0;
      end
      @(negedge CLK);
    end
    n_cmp++;
    if (obs !== 43'd0 || Done !== 1'b1) begin
      n_err++;
      $display("FAIL ovr_done got %h/%b exp 0/1", obs, Done);
    end
    @(negedge CLK);
`ifdef RESULT_SERIALIZER_OVERRUN_EN
    n_cmp++;
    if (Overrun !== 1'b1) begin
      n_err++;
      $display("FAIL ovr_flag_sticky got %b exp 1", Overrun);
    end
`endif
  endtask

  task automatic test_reset_abort;
    drive_matrix(0);
    Load = 1'b1;
    bus.OutReady = 1'b1;
    @(negedge CLK);
    Load = 1'b0;
    for (int k = 0; k < 10; k++) begin
      n_cmp++;
      if (obs !== elem(0, k)) begin
        n_err++;
        $display("FAIL abort_elem k=%0d got %h exp %h", k, obs, elem(0, k));
      end
      if (k == 9) reset = 1'b1;
      @(negedge CLK);
    end
    n_cmp++;
    if ({obs, Done} !== 44'd0) begin
      n_err++;
      $display("FAIL abort_outputs got %h exp 0", {obs, Done});
    end
`ifdef RESULT_SERIALIZER_OVERRUN_EN
    n_cmp++;
    if (Overrun !== 1'b0) begin
      n_err++;
      $display("FAIL abort_overrun got %b exp 0", Overrun);
    end
`endif
    reset = 1'b0;
    @(negedge CLK);
    n_cmp++;
    if ({obs, Done} !== 44'd0) begin
      n_err++;
      $display("FAIL abort_no_done got %h exp 0", {obs, Done});
    end
    Load = 1'b1;
    @(negedge CLK);
    Load = 1'b0;
    for (int k = 0; k < 16; k++) begin
      n_cmp++;
      if (obs !== elem(0, k)) begin
        n_err++;
        $display("FAIL abort_restart k=%0d got %h exp %h", k, obs, elem(0, k));
      end
      @(negedge CLK);
    end
    n_cmp++;
    if (Done !== 1'b1) begin
      n_err++;
      $display("FAIL abort_restart_done got %b exp 1", Done);
    end
    @(negedge CLK);
  endtask

  task automatic test_extremes;
    drive_matrix(3);
    Load = 1'b1;
    bus.OutReady = 1'b1;
    @(negedge CLK);
    Load = 1'b0;
    for (int k = 0; k < 16; k++) begin
      n_cmp++;
      if (obs !== elem(3, k)) begin
        n_err++;
        $display("FAIL extreme_elem k=%0d got %h exp %h", k, obs, elem(3, k));
      end
      @(negedge CLK);
    end
    n_cmp++;
    if (Done !== 1'b1) begin
      n_err++;
      $display("FAIL extreme_done got %b exp 1", Done);
    end
    @(negedge CLK);
  endtask

  initial begin
    test_reset;
    test_stream;
    test_stall;
    test_back_to_back;
    test_overrun;
    test_reset_abort;
    test_extremes;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/result_matrix_serializer.md
Name: result_matrix_serializer

Overview:
- Output-side counterpart of the parallel input capture register: accepts the full 4x4 complex result matrix C in one cycle.
- Streams C out one complex element per transfer over a valid/ready handshake, in row-major order.
- Sits between the 4x4 complex matrix multiplier core and the downstream consumer (UART/host interface).
- Double role: holding register for C plus parallel-to-serial converter.

Parameters:
- Width, 18, bit width of each real/imag component of C. Signed, two's complement. Sized for 8-bit operands, 4-term complex accumulation.

Ports:
- CLK  input  1  clock; all logic on posedge.
- reset  input  1  synchronous, active-high reset.
- Load  input  1  strobe: CRealFlat/CImagFlat hold a valid result matrix.
- CRealFlat  input  16*Width  real parts; element (r,c), r,c in 0..3, at bits [(4*r+c)*Width +: Width].
- CImagFlat  input  16*Width  imag parts; same packing.
- Busy  output  1  high while the block is in SEND.
- OutValid  output  1  OutReal/OutImag/OutRow/OutCol/OutLast are valid.
- OutReady  input  1  consumer accepts the current element.
- OutReal  output  Width  signed real part of the current element.
- OutImag  output  Width  signed imag part of the current element.
- OutRow  output  2  row index r of the current element.
- OutCol  output  2  column index c of the current element.
- OutLast  output  1  high with element (3,3).
- Done  output  1  one-cycle pulse after the final transfer.

Behaviour:
- Reset, synchronous and active-high, has priority over everything.
  - State goes to IDLE; the 16-entry buffer and index clear to 0.
  - All outputs are 0: Busy, OutValid, OutReal, OutImag, OutRow, OutCol, OutLast, Done.
  - Reset asserted mid-stream aborts the stream; no Done pulse.
- States:
  - IDLE: Load=1 captures both flat buses into the internal buffer, sets index=0, goes to SEND. Load=0 stays in IDLE.
  - SEND: OutValid=1. Outputs present element index k, where OutRow=k[3:2] and OutCol=k[1:0]. OutLast=(k==15).
- Latency: Load sampled at edge N gives OutValid=1 with element (0,0) after edge N, i.e. one cycle.
- Transfer occurs when OutValid&&OutReady at a posedge.
  - k<15: k increments, stay in SEND.
  - k==15: go to IDLE, OutValid=0, Done=1 for exactly one cycle.
- Stall: while OutValid&&!OutReady, all output data/index fields stay stable. OutValid never drops without a transfer (only reset drops it).
- OutReady is ignored in IDLE.
- Load in SEND:
  - If not coinciding with the k==15 transfer, Load is ignored. The buffer is not modified.
  - Load in the same cycle as the k==15 transfer captures the new matrix. Block stays in SEND with k=0, so element (0,0) of the new matrix follows with no gap. Done still pulses.
- Data is passed through unmodified; no rounding, saturation, or sign change.
- Full-matrix throughput: 16 cycles with OutReady held at 1.

Optional Feature:
- Macro: RESULT_SERIALIZER_OVERRUN_EN.
- Defined:
  - Adds output port Overrun (1 bit), reset value 0.
  - Overrun sets sticky when Load=1 is ignored in SEND.
  - It clears only on reset.
- Undefined:
  - No Overrun port and no related logic.
  - Ignored Loads are silently dropped.

Test Plan:
- Reset then Load with C(r,c) real=16*r+c, imag=-(16*r+c), OutReady=1 -> OutValid rises 1 cycle later. 16 consecutive transfers: (0,0)=0/0 ... (3,3)=51/-51, OutLast only on the 16th. Done pulses 1 cycle. Busy falls together with OutValid.
- Same load, OutReady toggling 1,0,0,1,... -> no element skipped or duplicated. Outputs stable during stalls. Order and values identical to the previous test.
- Load a second matrix (all real=7) at transfer k=5 of a stream -> ignored. Remaining elements come from the first matrix. With the macro defined, Overrun=1 and stays set.
- Assert Load with an all-real=-1 matrix on the same edge as the k==15 transfer -> Done=1. Next cycle OutValid=1 with (0,0) real=-1, no idle cycle.
- Assert reset at k=9 -> next cycle all outputs 0, no Done pulse. A subsequent Load restarts from (0,0).
- Width extremes: C(1,2) real=-131072, imag=131071 (Width=18) -> emitted bit-exact at k=6.
